// File: rtl/ram4k_arbiter_if.sv
// Requester-side bus of the shared RAM arbiter: two identical request/grant/read-return ports.
interface ram4k_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/ram4k_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port RAM, with a full-memory clear sweep.
module ram4k_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    ram4k_arbiter_if.slave    bus,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;          // 0: A favoured, 1: B favoured
    logic              clr_done_q, clr_done_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_in_q, last_in_d;

    logic arb_en;
    logic a_gnt;
    logic b_gnt;

    // Grants and RAM port steering; rst_n gating keeps grants and loads low during reset.
    always_comb begin
        arb_en   = rst_n && (state_q == ST_IDLE);
        a_gnt    = arb_en && bus.a_req && (!bus.b_req || !ptr_q);
        b_gnt    = arb_en && bus.b_req && (!bus.a_req ||  ptr_q);
        ram_addr = last_addr_q;
        ram_in   = last_in_q;
        ram_load = 1'b0;
        if (state_q == ST_CLEAR) begin
            ram_addr = cnt_q;
            ram_in   = '0;
            ram_load = rst_n;
        end else if (a_gnt) begin
            ram_addr = bus.a_addr;
            ram_in   = bus.a_wdata;
            ram_load = bus.a_we;
        end else if (b_gnt) begin
            ram_addr = bus.b_addr;
            ram_in   = bus.b_wdata;
            ram_load = bus.b_we;
        end
        last_addr_d = ram_addr;
        last_in_d   = ram_in;
    end

    // Next-state, pointer, clear counter and read-return logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        a_rvalid_d = a_gnt && !bus.a_we;
        b_rvalid_d = b_gnt && !bus.b_we;
        a_rdata_d  = a_rvalid_d ? ram_out : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? ram_out : b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (a_gnt) begin
                    ptr_d = 1'b1;
                end else if (b_gnt) begin
                    ptr_d = 1'b0;
                end
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = ADDR_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            clr_done_q  <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            last_addr_q <= '0;
            last_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            clr_done_q  <= clr_done_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            last_addr_q <= last_addr_d;
            last_in_q   <= last_in_d;
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign busy         = (state_q == ST_CLEAR);
    assign clr_done     = clr_done_q;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed bench for ram4k_arbiter: vector table for arbitration/read-return, hand sequences for clear and reset.
module tb_ram4k_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_start;
    logic        busy;
    logic        clr_done;
    logic [15:0] ram_in;
    logic [11:0] ram_addr;
    logic        ram_load;
    logic [15:0] ram_out;
    logic [15:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    ram4k_arbiter_if #(.DATA_W(16), .ADDR_W(12)) bus ();

    ram4k_arbiter #(.DATA_W(16), .ADDR_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .ram_in    (ram_in),
        .ram_addr  (ram_addr),
        .ram_load  (ram_load),
        .ram_out   (ram_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write at the rising edge.
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
    end

    typedef struct {
        logic        a_req, a_we;
        logic [11:0] a_addr;
        logic [15:0] a_wd;
        logic        b_req, b_we;
        logic [11:0] b_addr;
        logic [15:0] b_wd;
        logic        ea_gnt, eb_gnt, e_load;
        logic [11:0] e_addr;
        logic        ea_rv, eb_rv;
        logic [15:0] ea_rd, eb_rd;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(
        input logic ar, input logic aw, input logic [11:0] aa, input logic [15:0] ad,
        input logic br, input logic bw, input logic [11:0] ba, input logic [15:0] bd,
        input logic ga, input logic gb, input logic ld, input logic [11:0] ea,
        input logic rva, input logic rvb, input logic [15:0] rda, input logic [15:0] rdb);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wd = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wd = bd;
        v.ea_gnt = ga; v.eb_gnt = gb; v.e_load = ld; v.e_addr = ea;
        v.ea_rv = rva; v.eb_rv = rvb; v.ea_rd = rda; v.eb_rd = rdb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [11:0] a, input logic [15:0] d);
        bus.a_req = r; bus.a_we = w; bus.a_addr = a; bus.a_wdata = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [11:0] a, input logic [15:0] d);
        bus.b_req = r; bus.b_we = w; bus.b_addr = a; bus.b_wdata = d;
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 4096; i++) mem[i] = 16'hDEAD;

        vecs[0]  = mk(1,1,12'h005,16'h1234, 0,0,12'h000,16'h0000, 1,0,1,12'h005, 0,0,16'h0000,16'h0000);
        vecs[1]  = mk(1,0,12'h005,16'h0000, 0,0,12'h000,16'h0000, 1,0,0,12'h005, 0,0,16'h0000,16'h0000);
        vecs[2]  = mk(0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 0,0,0,12'h005, 1,0,16'h1234,16'h0000);
        vecs[3]  = mk(1,1,12'h010,16'hAAAA, 1,1,12'h020,16'hBBBB, 0,1,1,12'h020, 0,0,16'h1234,16'h0000);
        vecs[4]  = mk(1,1,12'h010,16'hAAAA, 1,0,12'h010,16'h0000, 1,0,1,12'h010, 0,0,16'h1234,16'h0000);
        vecs[5]  = mk(1,0,12'h020,16'h0000, 1,0,12'h010,16'h0000, 0,1,0,12'h010, 0,0,16'h1234,16'h0000);
        vecs[6]  = mk(1,0,12'h020,16'h0000, 0,0,12'h000,16'h0000, 1,0,0,12'h020, 0,1,16'h1234,16'hAAAA);
        vecs[7]  = mk(0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 0,0,0,12'h020, 1,0,16'hBBBB,16'hAAAA);
        vecs[8]  = mk(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,1,0,12'h005, 0,0,16'hBBBB,16'hAAAA);
        vecs[9]  = mk(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,1,0,12'h005, 0,1,16'hBBBB,16'h1234);
        vecs[10] = mk(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,1,0,12'h005, 0,1,16'hBBBB,16'h1234);
        vecs[11] = mk(1,0,12'h005,16'h0000, 1,0,12'h005,16'h0000, 1,0,0,12'h005, 0,1,16'hBBBB,16'h1234);
        vecs[12] = mk(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,1,0,12'h005, 1,0,16'h1234,16'h1234);
        vecs[13] = mk(0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 0,0,0,12'h005, 0,1,16'h1234,16'h1234);

        rst_n = 1'b0;
        clr_start = 1'b0;
        drive_a(0, 0, 12'h000, 16'h0000);
        drive_b(0, 0, 12'h000, 16'h0000);
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clr_done", 32'(clr_done), 0);
        chk("rst_ram_load", 32'(ram_load), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_in", 32'(ram_in), 0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("rst_b_rdata", 32'(bus.b_rdata), 0);

        step();
        rst_n = 1'b1;

        // Table: drive one cycle's requests, check combinational and registered outputs mid-cycle.
        for (int i = 0; i < 14; i++) begin
            drive_a(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd);
            drive_b(vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wd);
            #1;
            chk($sformatf("v%0d_a_gnt", i), 32'(bus.a_gnt), 32'(vecs[i].ea_gnt));
            chk($sformatf("v%0d_b_gnt", i), 32'(bus.b_gnt), 32'(vecs[i].eb_gnt));
            chk($sformatf("v%0d_ram_load", i), 32'(ram_load), 32'(vecs[i].e_load));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(vecs[i].ea_rv));
            chk($sformatf("v%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(vecs[i].eb_rv));
            chk($sformatf("v%0d_a_rdata", i), 32'(bus.a_rdata), 32'(vecs[i].ea_rd));
            chk($sformatf("v%0d_b_rdata", i), 32'(bus.b_rdata), 32'(vecs[i].eb_rd));
            step();
        end

        // Continuous requests from both: pointer now favours A, grants must alternate.
        drive_a(1, 0, 12'h005, 16'h0000);
        drive_b(1, 0, 12'h005, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("alt%0d_a_gnt", i), 32'(bus.a_gnt), 32'((i % 2) == 0));
            chk($sformatf("alt%0d_b_gnt", i), 32'(bus.b_gnt), 32'((i % 2) != 0));
            step();
        end
        drive_b(0, 0, 12'h000, 16'h0000);

        // Clear sweep with a read granted in the clr_start cycle.
        drive_a(1, 1, 12'h000, 16'hBEEF);
        step();
        drive_a(1, 1, 12'hFFF, 16'hBEEF);
        step();
        drive_a(1, 0, 12'hFFF, 16'h0000);
        clr_start = 1'b1;
        #1;
        chk("clr_start_a_gnt", 32'(bus.a_gnt), 1);
        step();
        clr_start = 1'b0;
        drive_a(1, 0, 12'h000, 16'h0000);
        #1;
        chk("clr_first_busy", 32'(busy), 1);
        chk("clr_inflight_rvalid", 32'(bus.a_rvalid), 1);
        chk("clr_inflight_rdata", 32'(bus.a_rdata), 32'h0000BEEF);
        n = 0;
        bad = 0;
        while (busy && n < 6000) begin
            if (bus.a_gnt || !ram_load || ram_addr != n[11:0] || ram_in != 16'h0000 || clr_done) bad++;
            n++;
            step();
        end
        chk("clr_cycles", 32'(n), 4096);
        chk("clr_sweep_bad_cycles", 32'(bad), 0);
        chk("clr_done_pulse", 32'(clr_done), 1);
        chk("clr_end_busy", 32'(busy), 0);
        chk("clr_end_a_gnt", 32'(bus.a_gnt), 1);
        step();
        chk("clr_done_drop", 32'(clr_done), 0);
        chk("rd000_rvalid", 32'(bus.a_rvalid), 1);
        chk("rd000_rdata", 32'(bus.a_rdata), 0);
        drive_a(1, 0, 12'hFFF, 16'h0000);
        step();
        drive_a(0, 0, 12'h000, 16'h0000);
        chk("rdfff_rvalid", 32'(bus.a_rvalid), 1);
        chk("rdfff_rdata", 32'(bus.a_rdata), 0);

        // Reset in the middle of a sweep.
        drive_a(1, 1, 12'h000, 16'hBEEF);
        step();
        drive_a(0, 0, 12'h000, 16'h0000);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        drive_a(1, 0, 12'h000, 16'h0000);
        n = 0;
        while (!(busy && ram_addr == 12'h800) && n < 6000) begin
            n++;
            step();
        end
        chk("rst_mid_reached_800", 32'(busy && ram_addr == 12'h800), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_ram_load", 32'(ram_load), 0);
        chk("rstmid_ram_addr", 32'(ram_addr), 0);
        chk("rstmid_a_gnt", 32'(bus.a_gnt), 0);
        chk("rstmid_clr_done", 32'(clr_done), 0);
        step();
        step();
        rst_n = 1'b1;
        drive_b(1, 0, 12'h000, 16'h0000);
        #1;
        chk("post_rst_a_gnt", 32'(bus.a_gnt), 1);
        chk("post_rst_b_gnt", 32'(bus.b_gnt), 0);
        step();
        drive_a(0, 0, 12'h000, 16'h0000);
        drive_b(0, 0, 12'h000, 16'h0000);
        chk("post_rst_rvalid", 32'(bus.a_rvalid), 1);
        chk("post_rst_rdata", 32'(bus.a_rdata), 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (clr_done || busy) bad++;
            step();
        end
        chk("post_rst_no_clr_done", 32'(bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram4k_arbiter.md
RAM4K_ARBITER -- requirements
Module: ram4k_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, shall set the width of the RAM data word.
REQ-002 Parameter ADDR_W, default 12, shall set the width of the RAM address (4096 words).
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 a_req, a_we  input  1 each  shall be requester A's access request and write-enable (1=write, 0=read).
REQ-006 a_addr  input  ADDR_W, a_wdata  input  DATA_W  shall be requester A's address and write data.
REQ-007 a_gnt  output  1  shall flag that A's request is accepted this cycle.
REQ-008 a_rvalid  output  1, a_rdata  output  DATA_W  shall return A's read data.
REQ-009 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata shall mirror REQ-005..008 for requester B.
REQ-010 clr_start  input  1  shall request a full-memory clear.
REQ-011 busy  output  1  shall be high while a clear is in progress.
REQ-012 clr_done  output  1  shall pulse for one cycle when a clear completes.
REQ-013 ram_in  output  DATA_W, ram_addr  output  ADDR_W, ram_load  output  1  shall drive the RAM's write data, address and load.
REQ-014 ram_out  input  DATA_W  shall be the RAM's combinational read data for ram_addr.

Function
REQ-015 States: IDLE (arbitrate requesters) and CLEAR (sweep); no other states.
REQ-016 In IDLE, a_gnt/b_gnt shall be combinational from req and the round-robin pointer; at most one grant high per cycle.
REQ-017 One requesting port: grant it. Both requesting: grant the port the pointer favours.
REQ-018 On every granted cycle the pointer shall move to favour the non-granted port; with no grant it shall hold.
REQ-019 Granted port's addr drives ram_addr and wdata drives ram_in in the same cycle; ram_load = granted port's we.
REQ-020 Granted write shall commit at the rising edge ending the grant cycle.
REQ-021 Granted read: ram_out registered at that edge into x_rdata; x_rvalid high exactly the following cycle (latency 1).
REQ-022 x_rdata shall hold its last value when x_rvalid is low.
REQ-023 Requesters hold req/we/addr/wdata until gnt is sampled high; one transaction per grant; back-to-back grants allowed.
REQ-024 No grant: ram_load = 0, ram_addr and ram_in hold their last driven values.
REQ-025 clr_start sampled high in IDLE enters CLEAR next cycle; a grant in that same cycle still completes normally.
REQ-026 CLEAR: 12-bit counter from 0; each cycle ram_addr = counter, ram_in = 0, ram_load = 1, counter += 1.
REQ-027 CLEAR lasts exactly 4096 cycles; after writing address 4095, return to IDLE, clr_done high for the first IDLE cycle.
REQ-028 busy shall equal (state == CLEAR).
REQ-029 During CLEAR: no grants, requests stall, clr_start ignored; a read already granted still gets its rvalid.
REQ-030 The pointer shall be unchanged by a clear.

Reset
REQ-031 rst_n low shall immediately force: state IDLE, counter 0, pointer favours A, gnts 0, rvalids 0, rdatas 0, busy 0, clr_done 0, ram_load 0, ram_addr 0, ram_in 0.
REQ-032 Reset during CLEAR shall abort the sweep with no clr_done; cleared-word contents are not guaranteed.
REQ-033 ram_load shall never be high while rst_n is low.

Verification
REQ-034 After reset: A writes 0x1234 to 0x005, then reads 0x005 -> a_gnt each cycle, a_rvalid one cycle after read grant, a_rdata = 0x1234.
REQ-035 A and B request continuously from reset -> grants alternate A,B,A,B; no cycle has both gnts.
REQ-036 Only B requests for 3 cycles, then both -> B,B,B granted, then A next.
REQ-037 Fill 0x000 and 0xFFF with 0xBEEF, pulse clr_start -> busy high 4096 cycles, clr_done one cycle, both reads return 0x0000.
REQ-038 A requests during CLEAR -> a_gnt low until first IDLE cycle, then granted.
REQ-039 rst_n low at counter 0x800 -> outputs at reset values at once, no clr_done; 0x000 reads 0.
